messbauer_scan_sequencer: RTL

- Master timing controller for the Messbauer test environment.
- Steps through the velocity channels of a spectrum scan and emits the start and channel pulses.
- Requests one burst from the diff-discriminator signal generator per channel and checks that the burst finishes inside the channel dwell window.
- Counts completed scans and stops after a programmed number, or runs forever.

---
 rtl/messbauer_scan_sequencer_if.sv | 40 ++++
 rtl/messbauer_scan_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/messbauer_scan_sequencer_if.sv
// Signal bundle between the Messbauer scan sequencer and its environment
// (run control, discriminator generator handshake, scan timing outputs).
interface messbauer_scan_sequencer_if;
    logic        run;
    logic        gen_done;
    logic        start;
    logic        channel;
    logic [9:0]  channel_index;
    logic        gen_request;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [15:0] scan_count;

    modport master (
        input  run,
        input  gen_done,
        output start,
        output channel,
        output channel_index,
        output gen_request,
        output busy,
        output done,
        output overrun,
        output scan_count
    );

    modport slave (
        output run,
        output gen_done,
        input  start,
        input  channel,
        input  channel_index,
        input  gen_request,
        input  busy,
        input  done,
        input  overrun,
        input  scan_count
    );
endinterface

// File: rtl/messbauer_scan_sequencer.sv
// Master timing controller for the Messbauer spectrum scan: steps velocity
// channels, emits start/channel pulses and supervises one generator burst per channel.
module messbauer_scan_sequencer #(
    parameter int CHANNEL_NUMBER      = 512,
    parameter int CHANNEL_DWELL       = 2000,
    parameter int CHANNEL_PULSE_WIDTH = 2,
    parameter int START_PULSE_WIDTH   = 4,
    parameter int SCAN_CYCLES         = 0
) (
    input  logic                        aclk,
    input  logic                        areset_n,
    messbauer_scan_sequencer_if.master  bus
);

    localparam logic [15:0] DWELL_LAST   = 16'(CHANNEL_DWELL - 1);
    localparam logic [15:0] CH_PULSE     = 16'(CHANNEL_PULSE_WIDTH);
    localparam logic [15:0] ST_PULSE     = 16'(START_PULSE_WIDTH);
    localparam logic [9:0]  LAST_CHANNEL = 10'(CHANNEL_NUMBER - 1);
    localparam logic [15:0] SCAN_LIMIT   = 16'(SCAN_CYCLES);
    localparam bit          FREE_RUN     = (SCAN_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [15:0] dwell_q,      dwell_d;
    logic [9:0]  index_q,      index_d;
    logic        start_q,      start_d;
    logic        channel_q,    channel_d;
    logic        request_q,    request_d;
    logic        busy_q,       busy_d;
    logic        done_q,       done_d;
    logic        overrun_q,    overrun_d;
    logic [15:0] scan_count_q, scan_count_d;

    logic [15:0] dwell_inc;
    logic [15:0] scan_inc;
    logic        window_end;
    logic        launch;
    logic [9:0]  launch_index;

    // NOTE: sequential state uses non-blocking assignments only; the async
    // reset clears every output so the bus drops to 0 the instant areset_n falls.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= IDLE;
            dwell_q      <= '0;
            index_q      <= '0;
            start_q      <= 1'b0;
            channel_q    <= 1'b0;
            request_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            scan_count_q <= '0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            index_q      <= index_d;
            start_q      <= start_d;
            channel_q    <= channel_d;
            request_q    <= request_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            scan_count_q <= scan_count_d;
        end
    end

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        index_d      = index_q;
        start_d      = start_q;
        channel_d    = channel_q;
        request_d    = request_q;
        busy_d       = busy_q;
        done_d       = done_q;
        overrun_d    = overrun_q;
        scan_count_d = scan_count_q;
        dwell_inc    = dwell_q + 16'd1;
        scan_inc     = scan_count_q + 16'd1;
        window_end   = (dwell_q == DWELL_LAST);
        launch       = 1'b0;
        launch_index = '0;

        unique case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                index_d = '0;
                if (bus.run) begin
                    launch       = 1'b1;
                    launch_index = '0;
                    overrun_d    = 1'b0;
                    scan_count_d = '0;
                end
            end

            PULSE, DWELL: begin
                dwell_d   = dwell_inc;
                channel_d = (dwell_inc < CH_PULSE);
                // start is timed from the channel-0 edge, so it may outlast PULSE
                start_d   = (index_q == 10'd0) && (dwell_inc < ST_PULSE);
                if (state_q == PULSE && dwell_inc >= CH_PULSE) begin
                    state_d = DWELL;
                end
                if (bus.gen_done) begin
                    request_d = 1'b0;
                end

                if (window_end) begin
                    // a gen_done on the very last cycle still counts as on time
                    if (request_q && !bus.gen_done) begin
                        overrun_d = 1'b1;
                    end
                    request_d = 1'b0;

                    if (!bus.run) begin
                        state_d   = IDLE;
                        index_d   = '0;
                        busy_d    = 1'b0;
                        dwell_d   = '0;
                        channel_d = 1'b0;
                        start_d   = 1'b0;
                    end else if (index_q < LAST_CHANNEL) begin
                        launch       = 1'b1;
                        launch_index = index_q + 10'd1;
                    end else begin
                        scan_count_d = scan_inc;
                        if (!FREE_RUN && scan_inc == SCAN_LIMIT) begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            busy_d    = 1'b0;
                            index_d   = '0;
                            dwell_d   = '0;
                            channel_d = 1'b0;
                            start_d   = 1'b0;
                        end else begin
                            launch       = 1'b1;
                            launch_index = '0;
                        end
                    end
                end
            end

            DONE: begin
                busy_d = 1'b0;
                if (!bus.run) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // channel launch shared by scan start, channel advance and scan wrap
        if (launch) begin
            state_d   = PULSE;
            index_d   = launch_index;
            dwell_d   = '0;
            channel_d = 1'b1;
            request_d = 1'b1;
            busy_d    = 1'b1;
            start_d   = (launch_index == 10'd0);
        end
    end

    assign bus.start         = start_q;
    assign bus.channel       = channel_q;
    assign bus.channel_index = index_q;
    assign bus.gen_request   = request_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.overrun       = overrun_q;
    assign bus.scan_count    = scan_count_q;

endmodule
